systolic_feeder: RTL and testbench
==================================

# systolic_feeder

- Edge feeder for the N×N systolic PE array: it is the transmitter side of the PE `a_in`/`b_in`/`clear` interface.
- Holds one A tile (N×K) and one B tile (K×N), loaded through a write port.
- On `start`, pulses `clear` to the array, then drives skewed operand wavefronts into the west (`a_edge`) and north (`b_edge`) edges.
- After the drain interval it pulses `done`; every PE `c_out` then holds C = A·B.

## Interface
- `WIDTH`, 8, operand width; matches the PE `WIDTH`.
- `N`, 2, array dimension (rows = columns); N ≥ 1.
- `K`, 2, inner dimension (tile depth); K ≥ 1.
- `IDX_W`, `$clog2(max(N,K,2))`, width of the write index.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wr_en` input 1: tile write strobe.
- `wr_sel` input 1: 0 = A tile, 1 = B tile.
- `wr_row` input IDX_W: A row i, or B row k.
- `wr_col` input IDX_W: A column k, or B column j.
- `wr_data` input WIDTH: element value.
- `start` input 1: begin a job (level sampled).
- `busy` output 1: high from the cycle after accepted `start` through the DONE state.
- `done` output 1: one-cycle pulse; all PE results are valid.
- `clear` output 1: connects to the PE `clear` of every PE.
- `a_edge` output N*WIDTH: lane i drives `a_in` of PE(i,0).
- `b_edge` output N*WIDTH: lane j drives `b_in` of PE(0,j).

## Operation
- **State machine:** IDLE → CLEAR (1 cycle) → STREAM (K+N−1 cycles) → DRAIN (N−1 cycles; skipped when N=1) → DONE (1 cycle) → IDLE.
- **Start:** `start` is accepted only in IDLE. While busy it is ignored; no queueing.
- **Writes:** accepted in IDLE only. Writes in any other state are dropped. Indices out of range (A: i≥N or k≥K; B: k≥K or j≥N) are dropped.
- **CLEAR:** `clear`=1; all edge lanes are 0.
- **STREAM, cycle t (t = 0 … K+N−2):**
  - `a_edge[i]` = A[i][t−i] if 0 ≤ t−i < K, else 0.
  - `b_edge[j]` = B[t−j][j] if 0 ≤ t−j < K, else 0.
- **DRAIN / DONE / IDLE:** all lanes are 0, so PE accumulators hold their value.
- **Registering:** all outputs are registered; no combinational path from inputs to outputs.
- **Reset:** forces IDLE. All outputs and both tile buffers go to 0. This holds even when reset is asserted mid-job; the partial job is abandoned.
- **Tile lifetime:** tiles persist across jobs. A repeated `start` recomputes with the same data.

## Timing
- `start` high in cycle 0 → `clear`=1 in cycle 1 → STREAM in cycles 2 … K+N.
- DRAIN occupies cycles K+N+1 … K+2N−1.
- `done`=1 in cycle K+2N; `busy` falls in cycle K+2N+1.
- Last PE(N−1,N−1) accumulation happens at the end of cycle K+2N−1. All `c_out` values are stable while `done`=1 and stay stable until the next `clear`.
- Back-to-back jobs: the earliest next `start` is sampled in cycle K+2N+1 (IDLE).
- Arithmetic: the feeder performs none. The 2·WIDTH accumulator wrap behaviour is the PE's.

## Configuration
- `FEEDER_JOB_CNT_EN` defined:
  - adds output `job_count` (16 bits, reset 0);
  - increments in the cycle `done`=1;
  - wraps from 0xFFFF to 0.
- `FEEDER_JOB_CNT_EN` undefined: the port and counter do not exist. All other behaviour is identical.

## Structure
- Shared package `tpu_pkg` contains:
  - the state enum `feeder_state_t` (IDLE, CLEAR, STREAM, DRAIN, DONE);
  - constants `SEL_A`=0 and `SEL_B`=1.
- Sub-module `tile_buf` (ROWS×COLS×WIDTH register array):
  - synchronous write port with range check;
  - combinational read by (row, col);
  - async reset to 0;
  - instantiated twice (A: N×K, B: K×N).
- Skew indexing (t−i, t−j) lives in `systolic_feeder`, driven by a single STREAM counter.

## Test plan
- **Basic job (N=2, K=2):** load A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse `start`.
  - Edge sequence: `a_edge` lanes (1,0), (2,3), (0,4); `b_edge` lanes (5,0), (7,6), (0,8).
  - Cycle timing: `clear` in cycle 1, `done` in cycle 6.
  - With a 2×2 PE array attached: C=[[19,22],[43,50]].
- **Overflow (N=2, K=2):** A and B all 255, PE array attached → every `c_out` = 64514 (130050 mod 65536).
- **Blocked start and writes:** assert `start` and write A[0][0]=9 during STREAM → no second job, A unchanged; rerun gives the same C.
- **Mid-job reset:** assert `rst` in the first STREAM cycle → all outputs 0 next cycle, state IDLE, buffers 0; a new job then yields C = 0.
- **Out-of-range write:** write A with `wr_row`=2 (N=2) → ignored; the checksum of both buffers is unchanged.
- **Job counter:** with `FEEDER_JOB_CNT_EN`, three jobs → `job_count`=3. Preload the counter at 0xFFFF via force, run one job → `job_count`=0.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic feeder: FSM state encoding,
// tile write selects and the write-index sizing helper.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // max(n, k, 2): the span the write index must be able to address
    function automatic int idx_span(input int n, input int k);
        int m;
        m = (n > k) ? n : k;
        return (m > 2) ? m : 2;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Host-side bus of the systolic feeder: tile write port, job start and
// status, plus the clear/edge lanes that go to the PE array.
interface systolic_feeder_if #(
    parameter int WIDTH = 8,
    parameter int N     = 2,
    parameter int IDX_W = 1
);
    logic             wr_en;
    logic             wr_sel;
    logic [IDX_W-1:0] wr_row;
    logic [IDX_W-1:0] wr_col;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             busy;
    logic             done;
    logic             clear;
    logic [N*WIDTH-1:0] a_edge;
    logic [N*WIDTH-1:0] b_edge;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, done, clear, a_edge, b_edge
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, done, clear, a_edge, b_edge
    );
endinterface

// File: rtl/tile_buf.sv
// ROWS x COLS operand tile: range-checked synchronous write, NRD independent
// combinational read ports, asynchronous clear to zero.
module tile_buf #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int WIDTH = 8,
    parameter int IDX_W = 1,
    parameter int NRD   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_row,
    input  logic [IDX_W-1:0] wr_col,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_row  [NRD],
    input  logic [IDX_W-1:0] rd_col  [NRD],
    output logic [WIDTH-1:0] rd_data [NRD]
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [WIDTH-1:0] mem_q [ROWS][COLS];
    logic             wr_hit;

    assign wr_hit = we && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (wr_hit) begin
            mem_q[wr_row[RW-1:0]][wr_col[CW-1:0]] <= wr_data;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign rd_data[p] = ((int'(rd_row[p]) < ROWS) && (int'(rd_col[p]) < COLS))
                          ? mem_q[rd_row[p][RW-1:0]][rd_col[p][CW-1:0]] : '0;
    end
endmodule

// File: rtl/systolic_feeder.sv
// West/north edge feeder for an N x N systolic PE array (C = A * B).
// Optional job counter output is enabled by defining FEEDER_JOB_CNT_EN.
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 2,
    parameter int K     = 2,
    parameter int IDX_W = $clog2(idx_span(N, K))
) (
    input  logic clk,
    input  logic rst,
`ifdef FEEDER_JOB_CNT_EN
    output logic [15:0] job_count,
`endif
    systolic_feeder_if.slave bus
);
    localparam int T_LAST = K + N - 2;
    localparam int CNT_W  = $clog2(K + N + 1);

    feeder_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               clear_q, clear_d;
    logic [N*WIDTH-1:0] a_edge_q, a_edge_d;
    logic [N*WIDTH-1:0] b_edge_q, b_edge_d;
    logic [N-1:0]       lane_vld;
    int                 t_d;
    logic               wr_ok, a_we, b_we;

    logic [IDX_W-1:0] a_rd_row [N];
    logic [IDX_W-1:0] a_rd_col [N];
    logic [IDX_W-1:0] b_rd_row [N];
    logic [IDX_W-1:0] b_rd_col [N];
    logic [WIDTH-1:0] a_rd_data [N];
    logic [WIDTH-1:0] b_rd_data [N];

    assign wr_ok = bus.wr_en && (state_q == IDLE);
    assign a_we  = wr_ok && (bus.wr_sel == SEL_A);
    assign b_we  = wr_ok && (bus.wr_sel == SEL_B);

    tile_buf #(.ROWS(N), .COLS(K), .WIDTH(WIDTH), .IDX_W(IDX_W), .NRD(N)) u_a_buf (
        .clk(clk), .rst(rst), .we(a_we),
        .wr_row(bus.wr_row), .wr_col(bus.wr_col), .wr_data(bus.wr_data),
        .rd_row(a_rd_row), .rd_col(a_rd_col), .rd_data(a_rd_data)
    );

    tile_buf #(.ROWS(K), .COLS(N), .WIDTH(WIDTH), .IDX_W(IDX_W), .NRD(N)) u_b_buf (
        .clk(clk), .rst(rst), .we(b_we),
        .wr_row(bus.wr_row), .wr_col(bus.wr_col), .wr_data(bus.wr_data),
        .rd_row(b_rd_row), .rd_col(b_rd_col), .rd_data(b_rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE:   if (bus.start) state_d = CLEAR;
            CLEAR: begin
                state_d = STREAM;
                cnt_d   = '0;
            end
            STREAM: begin
                if (int'(cnt_q) == T_LAST) begin
                    state_d = (N > 1) ? DRAIN : DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (int'(cnt_q) == N - 2) state_d = DONE;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        clear_d = (state_d == CLEAR);
    end

    assign t_d = int'(cnt_d);

    // Lane i/j of wavefront t carries inner index t-i (A) and t-j (B)
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign a_rd_row[i] = IDX_W'(i);
        assign a_rd_col[i] = IDX_W'(t_d - i);
        assign b_rd_row[i] = IDX_W'(t_d - i);
        assign b_rd_col[i] = IDX_W'(i);
        assign lane_vld[i] = (state_d == STREAM) && (t_d >= i) && (t_d - i < K);
        assign a_edge_d[i*WIDTH +: WIDTH] = lane_vld[i] ? a_rd_data[i] : '0;
        assign b_edge_d[i*WIDTH +: WIDTH] = lane_vld[i] ? b_rd_data[i] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clear_q  <= 1'b0;
            a_edge_q <= '0;
            b_edge_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            clear_q  <= clear_d;
            a_edge_q <= a_edge_d;
            b_edge_q <= b_edge_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.clear  = clear_q;
    assign bus.a_edge = a_edge_q;
    assign bus.b_edge = b_edge_q;

`ifdef FEEDER_JOB_CNT_EN
    logic [15:0] job_cnt_q, job_cnt_d;

    assign job_cnt_d = job_cnt_q + {15'd0, done_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) job_cnt_q <= '0;
        else     job_cnt_q <= job_cnt_d;
    end

    assign job_count = job_cnt_q;
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder with a behavioural 2x2 PE array stub.
module tb_systolic_feeder;
    localparam int W  = 8;
    localparam int N  = 2;
    localparam int K  = 2;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
`ifdef FEEDER_JOB_CNT_EN
    logic [15:0] job_count;
    int exp_jobs = 0;
`endif

    systolic_feeder_if #(.WIDTH(W), .N(N), .IDX_W(IW)) bus ();

    systolic_feeder #(.WIDTH(W), .N(N), .K(K), .IDX_W(IW)) dut (
        .clk(clk),
        .rst(rst),
`ifdef FEEDER_JOB_CNT_EN
        .job_count(job_count),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int ref_a [N][K];
    int ref_b [K][N];

    // PE array stub: acc += a*b (2*W bits, wraps); a flows east, b flows south
    logic [15:0]  acc   [N][N];
    logic [W-1:0] a_fwd [N][N];
    logic [W-1:0] b_fwd [N][N];
    logic [W-1:0] a_in  [N][N];
    logic [W-1:0] b_in  [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) a_in[i][j] = bus.a_edge[i*W +: W];
                else        a_in[i][j] = a_fwd[i][j-1];
                if (i == 0) b_in[i][j] = bus.b_edge[j*W +: W];
                else        b_in[i][j] = b_fwd[i-1][j];
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst) begin
                    acc[i][j]   <= '0;
                    a_fwd[i][j] <= '0;
                    b_fwd[i][j] <= '0;
                end else begin
                    a_fwd[i][j] <= a_in[i][j];
                    b_fwd[i][j] <= b_in[i][j];
                    acc[i][j]   <= bus.clear ? 16'd0
                                 : acc[i][j] + 16'(a_in[i][j]) * 16'(b_in[i][j]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [N*W-1:0] exp_a(input int t);
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < K) v[i*W +: W] = W'(ref_a[i][t-i]);
        return v;
    endfunction

    function automatic logic [N*W-1:0] exp_b(input int t);
        logic [N*W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < K) v[j*W +: W] = W'(ref_b[t-j][j]);
        return v;
    endfunction

    function automatic logic [15:0] exp_c(input int i, input int j);
        int s;
        s = 0;
        for (int k = 0; k < K; k++) s += ref_a[i][k] * ref_b[k][j];
        return 16'(s);
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < N; i++) for (int k = 0; k < K; k++) ref_a[i][k] = 0;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) ref_b[k][j] = 0;
    endtask

    // Entered and left just after a rising edge while the DUT is IDLE
    task automatic wr(input logic sel, input int row, input int col, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = IW'(row);
        bus.wr_col  = IW'(col);
        bus.wr_data = W'(data);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        if (sel == 1'b0) begin
            if (row < N && col < K) ref_a[row][col] = data & 255;
        end else begin
            if (row < K && col < N) ref_b[row][col] = data & 255;
        end
    endtask

    task automatic run_job(input string tag, input bit inject);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk({tag, ".clear_ctl"}, {bus.clear, bus.busy, bus.done}, 3'b110);
        chk({tag, ".clear_edges"}, {bus.a_edge, bus.b_edge}, '0);
        for (int t = 0; t <= K + N - 2; t++) begin
            @(negedge clk);
            chk($sformatf("%s.stream%0d_ctl", tag, t), {bus.clear, bus.busy, bus.done}, 3'b010);
            chk($sformatf("%s.stream%0d_a", tag, t), bus.a_edge, exp_a(t));
            chk($sformatf("%s.stream%0d_b", tag, t), bus.b_edge, exp_b(t));
            if (inject && t == 0) begin
                bus.start = 1'b1;
                bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
                bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = 8'd9;
            end
            if (inject && t == 1) begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
        end
        for (int d = 0; d < N - 1; d++) begin
            @(negedge clk);
            chk($sformatf("%s.drain%0d_ctl", tag, d), {bus.clear, bus.busy, bus.done}, 3'b010);
            chk($sformatf("%s.drain%0d_edges", tag, d), {bus.a_edge, bus.b_edge}, '0);
        end
        @(negedge clk);
        chk({tag, ".done_ctl"}, {bus.clear, bus.busy, bus.done}, 3'b011);
        chk({tag, ".done_edges"}, {bus.a_edge, bus.b_edge}, '0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s.c%0d%0d", tag, i, j), acc[i][j], exp_c(i, j));
`ifdef FEEDER_JOB_CNT_EN
        exp_jobs++;
`endif
        @(negedge clk);
        chk({tag, ".idle_ctl"}, {bus.clear, bus.busy, bus.done}, 3'b000);
        @(posedge clk); #1;
    endtask

    typedef struct {
        string name;
        int    a [4];
        int    b [4];
        int    c [4];
    } vec_t;

    vec_t tbl [4];

    initial begin
        tbl[0].name = "basic";    tbl[0].a = '{1, 2, 3, 4};         tbl[0].b = '{5, 6, 7, 8};
        tbl[0].c = '{19, 22, 43, 50};
        tbl[1].name = "overflow"; tbl[1].a = '{255, 255, 255, 255}; tbl[1].b = '{255, 255, 255, 255};
        tbl[1].c = '{64514, 64514, 64514, 64514};
        tbl[2].name = "identity"; tbl[2].a = '{1, 0, 0, 1};         tbl[2].b = '{3, 4, 5, 6};
        tbl[2].c = '{3, 4, 5, 6};
        tbl[3].name = "mixed";    tbl[3].a = '{2, 0, 1, 3};         tbl[3].b = '{1, 1, 0, 2};
        tbl[3].c = '{2, 2, 1, 7};

        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_data = '0; bus.start = 1'b0;
        clear_ref();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctl", {bus.clear, bus.busy, bus.done}, 3'b000);
        chk("reset_edges", {bus.a_edge, bus.b_edge}, '0);
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < K; k++) wr(1'b0, i, k, tbl[v].a[i*K+k]);
            for (int k = 0; k < K; k++)
                for (int j = 0; j < N; j++) wr(1'b1, k, j, tbl[v].b[k*N+j]);
            run_job(tbl[v].name, 1'b0);
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    chk($sformatf("%s.tbl_c%0d%0d", tbl[v].name, i, j), acc[i][j], 64'(tbl[v].c[i*N+j]));
        end

        // start and a write while streaming are both dropped
        run_job("blocked", 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("blocked.no_rerun%0d", c), bus.busy, 1'b0);
        end
        @(posedge clk); #1;
        run_job("rerun", 1'b0);
        chk("rerun.c00_kept", acc[0][0], 64'(tbl[3].c[0]));

        wr(1'b0, 2, 0, 77); wr(1'b0, 0, 2, 77); wr(1'b1, 2, 0, 77);
        wr(1'b1, 0, 2, 77); wr(1'b0, 3, 3, 77);
        run_job("out_of_range", 1'b0);

        for (int r = 0; r < 6; r++) begin
            repeat (10) wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            run_job($sformatf("rand%0d", r), 1'b0);
        end

        // reset in the first streaming cycle abandons the job and empties the tiles
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_ref();
`ifdef FEEDER_JOB_CNT_EN
        exp_jobs = 0;
`endif
        @(negedge clk);
        chk("midrst_ctl", {bus.clear, bus.busy, bus.done}, 3'b000);
        chk("midrst_edges", {bus.a_edge, bus.b_edge}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_job("post_rst", 1'b0);
        chk("post_rst.c11_zero", acc[N-1][N-1], 64'd0);

`ifdef FEEDER_JOB_CNT_EN
        run_job("cnt1", 1'b0);
        run_job("cnt2", 1'b0);
        chk("job_count", job_count, 64'(exp_jobs));
        force dut.job_cnt_q = 16'hFFFF;
        #1 release dut.job_cnt_q;
        run_job("cnt_wrap", 1'b0);
        chk("job_count_wrap", job_count, 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
